// File: rtl/tile_pixel_pipe_if.sv
// Pixel-stream bundle between the VGA timing side, the map RAM and the colour register.
// Handshake: valid-only, no ready; a beat transfers on every clock where pix_valid/out_valid is high.
interface tile_pixel_pipe_if #(
   parameter int TILE_BITS = 5,
   parameter int COL_BITS  = 4,
   parameter int ROW_BITS  = 4
);
   logic                          pix_valid;
   logic [COL_BITS+TILE_BITS-1:0] pix_x;
   logic [ROW_BITS+TILE_BITS-1:0] pix_y;
   logic                          frame_start;
   logic                          game_over;
   logic [ROW_BITS+COL_BITS-1:0]  map_addr;
   logic [3:0]                    map_rdata;
   logic                          out_valid;
   logic [11:0]                   out_rgb;

   modport master (
      output pix_valid, pix_x, pix_y, frame_start, game_over, map_rdata,
      input  map_addr, out_valid, out_rgb
   );

   modport slave (
      input  pix_valid, pix_x, pix_y, frame_start, game_over, map_rdata,
      output map_addr, out_valid, out_rgb
   );
endinterface

// File: rtl/tile_pixel_pipe.sv
// Tile-map pixel renderer: coordinate -> map RAM address -> tile shape colour, 3-stage pipeline.
// Stage 0 issues the RAM read, stage 1 waits for the RAM, stage 2 shades.
module tile_pixel_pipe #(
   parameter int          TILE_BITS = 5,
   parameter int          MAP_COLS  = 16,
   parameter int          MAP_ROWS  = 16,
   parameter int          COL_BITS  = 4,
   parameter int          ROW_BITS  = 4,
   parameter int          BLINK_BIT = 4,
   parameter logic [11:0] GROUND_C  = 12'h0F0,
   parameter logic [11:0] FOOD_C    = 12'h0FF,
   parameter logic [11:0] BODY_C    = 12'hF00,
   parameter logic [11:0] HEAD_C    = 12'hF0F,
   parameter logic [11:0] DEAD_C    = 12'h00F,
   parameter logic [11:0] BORDER_C  = 12'h000
) (
   input logic              clk,
   input logic              rst,
   tile_pixel_pipe_if.slave bus
);
   localparam int T = 1 << TILE_BITS;
   localparam logic [TILE_BITS-1:0] B_OFF  = TILE_BITS'(T / 4);
   localparam logic [TILE_BITS-1:0] TMB    = TILE_BITS'(T - T / 4);
   localparam logic [TILE_BITS-1:0] HALF   = TILE_BITS'(T / 2);
   localparam logic [COL_BITS:0]    COLS_W = (COL_BITS + 1)'(MAP_COLS);
   localparam logic [ROW_BITS:0]    ROWS_W = (ROW_BITS + 1)'(MAP_ROWS);

   logic [COL_BITS-1:0] col_in;
   logic [ROW_BITS-1:0] row_in;
   logic                oob_in;

   logic [ROW_BITS+COL_BITS-1:0] map_addr_q;
   logic [TILE_BITS-1:0]         ox0, oy0, ox1, oy1;
   logic                         oob0, oob1;
   logic                         v0, v1;
   logic                         out_valid_q;
   logic [11:0]                  out_rgb_q;
   logic [7:0]                   frame_cnt;
   logic                         blink;

   logic        hb, vb, in_shape;
   logic [11:0] shape_c, colour;

   assign col_in = bus.pix_x[COL_BITS+TILE_BITS-1 -: COL_BITS];
   assign row_in = bus.pix_y[ROW_BITS+TILE_BITS-1 -: ROW_BITS];
   assign oob_in = ({1'b0, col_in} >= COLS_W) || ({1'b0, row_in} >= ROWS_W);
   assign blink  = frame_cnt[BLINK_BIT];

   // Control and output registers; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         v0          <= 1'b0;
         v1          <= 1'b0;
         out_valid_q <= 1'b0;
         out_rgb_q   <= BORDER_C;
         map_addr_q  <= '0;
         frame_cnt   <= '0;
      end else begin
         v0          <= bus.pix_valid;
         map_addr_q  <= {row_in, col_in};
         v1          <= v0;
         out_valid_q <= v1;
         out_rgb_q   <= v1 ? colour : BORDER_C;
         if (bus.frame_start) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      ox0  <= bus.pix_x[TILE_BITS-1:0];
      oy0  <= bus.pix_y[TILE_BITS-1:0];
      oob0 <= oob_in;
      ox1  <= ox0;
      oy1  <= oy0;
      oob1 <= oob0;
   end

   // Shape decode: hb/vb are the centre bands; corner and end tiles trim them.
   always_comb begin
      hb       = (oy1 >= B_OFF) && (oy1 < TMB);
      vb       = (ox1 >= B_OFF) && (ox1 < TMB);
      in_shape = 1'b0;
      shape_c  = BODY_C;
      colour   = GROUND_C;
      case (bus.map_rdata)
         4'd0:  in_shape = 1'b0;
         4'd1: begin
            in_shape = hb && vb && !blink;
            shape_c  = FOOD_C;
         end
         4'd2:  in_shape = hb;
         4'd3:  in_shape = vb;
         4'd4:  in_shape = (hb && (ox1 < TMB))    || (vb && (oy1 < TMB));
         4'd5:  in_shape = (hb && (ox1 >= B_OFF)) || (vb && (oy1 < TMB));
         4'd6:  in_shape = (hb && (ox1 < TMB))    || (vb && (oy1 >= B_OFF));
         4'd7:  in_shape = (hb && (ox1 >= B_OFF)) || (vb && (oy1 >= B_OFF));
         4'd8:  in_shape = hb && (ox1 >= HALF);
         4'd9:  in_shape = hb && (ox1 < HALF);
         4'd10: in_shape = vb && (oy1 >= HALF);
         4'd11: in_shape = vb && (oy1 < HALF);
         4'd12: in_shape = hb && (ox1 >= B_OFF);
         4'd13: in_shape = hb && (ox1 < TMB);
         4'd14: in_shape = vb && (oy1 >= B_OFF);
         4'd15: in_shape = vb && (oy1 < TMB);
         default: in_shape = 1'b0;
      endcase
      if (bus.map_rdata >= 4'd12) shape_c = bus.game_over ? DEAD_C : HEAD_C;
      if (oob1)          colour = BORDER_C;
      else if (in_shape) colour = shape_c;
   end

   assign bus.map_addr  = map_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_rgb   = out_rgb_q;
endmodule

// File: tb/tb_tile_pixel_pipe.sv
// Scoreboard bench for tile_pixel_pipe: directed pixels with hand-computed colours and latency tags.
module tb_tile_pixel_pipe;
   localparam int TB = 5;
   localparam int CB = 5;
   localparam int RB = 5;
   localparam int PW = CB + TB;
   localparam int AW = CB + RB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tile_pixel_pipe_if #(.TILE_BITS(TB), .COL_BITS(CB), .ROW_BITS(RB)) bus ();

   tile_pixel_pipe #(.TILE_BITS(TB), .COL_BITS(CB), .ROW_BITS(RB)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Synchronous map RAM model, one cycle read latency.
   logic [3:0] map_mem [0:(1<<AW)-1];
   always @(posedge clk) bus.map_rdata <= map_mem[bus.map_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [11:0] exp_q[$];
   int          cyc_q[$];
   int          checks   = 0;
   int          failures = 0;
   bit          mon_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h at cyc=%0d", name, got, want, cyc);
      end
   endtask

   // Monitor: pops one expectation per valid output; idle cycles must show the border colour.
   always @(posedge clk) begin
      logic [11:0] e;
      int          c;
      #2;
      if (mon_en) begin
         if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out got=%h want=none at cyc=%0d", bus.out_rgb, cyc);
            end else begin
               e = exp_q.pop_front();
               c = cyc_q.pop_front();
               check("out_rgb", 32'(bus.out_rgb), 32'(e));
               check("latency", 32'(cyc), 32'(c + 3));
            end
         end else begin
            check("idle_valid", 32'(bus.out_valid), 32'd0);
            check("idle_rgb", 32'(bus.out_rgb), 32'h000);
         end
      end
   end

   task automatic drive_pix(input int x, input int y, input logic [11:0] e);
      @(posedge clk); #1;
      bus.pix_valid = 1'b1;
      bus.pix_x     = PW'(x);
      bus.pix_y     = PW'(y);
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.pix_valid = 1'b0;
      end
   endtask

   task automatic check_addr(input int want);
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      #1;
      check("map_addr", 32'(bus.map_addr), 32'(want));
   endtask

   task automatic set_tile(input int c, input int r, input int t);
      idle(3);
      map_mem[r * (1 << CB) + c] = 4'(t);
   endtask

   task automatic frame_pulses(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.frame_start = 1'b1;
         @(posedge clk); #1;
         bus.frame_start = 1'b0;
      end
   endtask

   // One-cycle reset with pix_valid held; the pixel under reset is lost, then re-accepted.
   task automatic mid_reset(input int x, input int y, input logic [11:0] e);
      int d;
      @(posedge clk); #1;
      rst           = 1'b1;
      bus.pix_valid = 1'b1;
      bus.pix_x     = PW'(x);
      bus.pix_y     = PW'(y);
      d             = cyc;
      while (cyc_q.size() > 0 && cyc_q[cyc_q.size()-1] + 3 >= d + 1) begin
         void'(exp_q.pop_back());
         void'(cyc_q.pop_back());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog got=timeout want=finish at cyc=%0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) map_mem[i] = 4'd0;
      bus.pix_valid   = 1'b0;
      bus.pix_x       = '0;
      bus.pix_y       = '0;
      bus.frame_start = 1'b0;
      bus.game_over   = 1'b0;
      rst             = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_rgb", 32'(bus.out_rgb), 32'h000);
      check("rst_addr", 32'(bus.map_addr), 32'd0);
      mon_en = 1'b1;

      // All-ground map, first row.
      for (int x = 0; x < 32; x++) drive_pix(x, 0, 12'h0F0);
      drive_pix(5, 0, 12'h0F0);
      check_addr(0);

      // Horizontal body at tile (1,2), inside and just above the band.
      set_tile(1, 2, 2);
      for (int x = 32; x < 64; x++) drive_pix(x, 72, 12'hF00);
      drive_pix(40, 72, 12'hF00);
      check_addr(65);
      drive_pix(32, 71, 12'h0F0);
      drive_pix(45, 71, 12'h0F0);
      drive_pix(63, 71, 12'h0F0);
      drive_pix(48, 87, 12'hF00);
      drive_pix(48, 88, 12'h0F0);

      set_tile(0, 0, 4);
      drive_pix(4, 12, 12'hF00);
      drive_pix(28, 12, 12'h0F0);
      drive_pix(12, 4, 12'hF00);
      drive_pix(12, 28, 12'h0F0);
      set_tile(0, 0, 5);
      drive_pix(4, 12, 12'h0F0);
      drive_pix(12, 4, 12'hF00);
      drive_pix(12, 28, 12'h0F0);
      set_tile(0, 0, 6);
      drive_pix(4, 12, 12'hF00);
      drive_pix(12, 4, 12'h0F0);
      set_tile(0, 0, 7);
      drive_pix(4, 12, 12'h0F0);
      drive_pix(28, 12, 12'hF00);
      drive_pix(12, 4, 12'h0F0);
      drive_pix(12, 28, 12'hF00);
      set_tile(0, 0, 3);
      drive_pix(16, 2, 12'hF00);
      drive_pix(2, 16, 12'h0F0);
      drive_pix(7, 16, 12'h0F0);
      drive_pix(8, 16, 12'hF00);
      drive_pix(23, 16, 12'hF00);
      drive_pix(24, 16, 12'h0F0);
      set_tile(0, 0, 8);
      drive_pix(20, 16, 12'hF00);
      drive_pix(10, 16, 12'h0F0);
      drive_pix(16, 16, 12'hF00);
      set_tile(0, 0, 9);
      drive_pix(10, 16, 12'hF00);
      drive_pix(16, 16, 12'h0F0);
      set_tile(0, 0, 10);
      drive_pix(16, 20, 12'hF00);
      drive_pix(16, 12, 12'h0F0);
      set_tile(0, 0, 11);
      drive_pix(16, 12, 12'hF00);
      drive_pix(16, 16, 12'h0F0);
      set_tile(0, 0, 13);
      drive_pix(20, 16, 12'hF0F);
      drive_pix(26, 16, 12'h0F0);
      set_tile(0, 0, 14);
      drive_pix(16, 8, 12'hF0F);
      drive_pix(16, 7, 12'h0F0);
      set_tile(0, 0, 15);
      drive_pix(16, 20, 12'hF0F);
      drive_pix(16, 28, 12'h0F0);

      // Food with frame-counted blink.
      set_tile(0, 0, 1);
      drive_pix(16, 16, 12'h0FF);
      drive_pix(2, 16, 12'h0F0);
      drive_pix(8, 8, 12'h0FF);
      drive_pix(24, 16, 12'h0F0);
      idle(4);
      frame_pulses(16);
      idle(2);
      drive_pix(16, 16, 12'h0F0);
      idle(4);
      frame_pulses(16);
      idle(2);
      drive_pix(16, 16, 12'h0FF);

      // Head, game over, out-of-map border and a gap in the stream.
      set_tile(0, 0, 12);
      drive_pix(20, 16, 12'hF0F);
      drive_pix(4, 16, 12'h0F0);
      idle(4);
      bus.game_over = 1'b1;
      drive_pix(20, 16, 12'h00F);
      drive_pix(4, 16, 12'h0F0);
      idle(4);
      bus.game_over = 1'b0;
      map_mem[16] = 4'd2;
      set_tile(15, 15, 2);
      drive_pix(512, 16, 12'h000);
      idle(1);
      drive_pix(16, 512, 12'h000);
      drive_pix(1023, 1023, 12'h000);
      drive_pix(496, 496, 12'hF00);
      idle(2);
      drive_pix(20, 16, 12'hF0F);

      // Reset in mid-stream with pix_valid held high.
      set_tile(0, 0, 2);
      for (int x = 0; x < 16; x++) drive_pix(x, 16, 12'hF00);
      mid_reset(16, 16, 12'hF00);
      for (int x = 17; x < 32; x++) drive_pix(x, 16, 12'hF00);

      idle(6);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
